// File: rtl/arm_cpu_pkg.sv
// Shared types and decode constants for the arm_cpu_core LEGv8-subset processor.
package arm_cpu_pkg;

   localparam int XLEN = 64;

   localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
   localparam logic [10:0] OP_ADDS  = 11'b10101011000;
   localparam logic [10:0] OP_SUBS  = 11'b11101011000;
   localparam logic [10:0] OP_LDUR  = 11'b11111000010;
   localparam logic [10:0] OP_STUR  = 11'b11111000000;
   localparam logic [10:0] OP_LSL   = 11'b11010011011;
   localparam logic [10:0] OP_LSR   = 11'b11010011010;
   localparam logic [5:0]  OP_B     = 6'b000101;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [4:0]  COND_LT  = 5'b01011;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'b000,
      ALU_ADD   = 3'b010,
      ALU_SUB   = 3'b011,
      ALU_AND   = 3'b100,
      ALU_OR    = 3'b101,
      ALU_XOR   = 3'b110,
      ALU_SHIFT = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_LT   = 2'd1,
      BR_CBZ  = 2'd2
   } br_kind_e;

   // toadd selects the zero-extended imm12 (ADDI) instead of the signed imm9
   typedef struct packed {
      logic     reg2loc;
      logic     alusrc;
      logic     toadd;
      logic     memtoreg;
      logic     regwrite;
      logic     memread;
      logic     memwrite;
      logic     flagenable;
      logic     uncondbr;
      br_kind_e branch;
      alu_op_e  aluop;
   } ctrl_t;

endpackage

// File: rtl/arm_cpu_core_if.sv
// Fetch, data-memory and debug-flag signals between arm_cpu_core and its memories.
interface arm_cpu_core_if;
   import arm_cpu_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_we;
   logic            dmem_re;
   logic [XLEN-1:0] dmem_rdata;
   logic [3:0]      flags;

   modport master (
      output imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re, flags,
      input  imem_data, dmem_rdata
   );

   modport slave (
      input  imem_addr, dmem_addr, dmem_wdata, dmem_we, dmem_re, flags,
      output imem_data, dmem_rdata
   );
endinterface

// File: rtl/arm_alu.sv
// Combinational 64-bit ALU with N/Z/V/C status; V and C are meaningful for add/subtract only.
module arm_alu
   import arm_cpu_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  alu_op_e         i_op,
   input  logic [5:0]      i_shamt,
   input  logic            i_shift_left,
   output logic [XLEN-1:0] o_result,
   output logic            o_n,
   output logic            o_z,
   output logic            o_v,
   output logic            o_c
);
   logic [XLEN-1:0] w_b_eff;
   logic [XLEN:0]   w_sum;

   always_comb begin
      // subtract is A + ~B + 1 so carry means "no borrow"
      w_b_eff  = (i_op == ALU_SUB) ? ~i_b : i_b;
      w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, (i_op == ALU_SUB)};
      o_result = '0;
      o_c      = 1'b0;
      o_v      = 1'b0;
      case (i_op)
         ALU_PASSB: o_result = i_b;
         ALU_ADD, ALU_SUB: begin
            o_result = w_sum[XLEN-1:0];
            o_c      = w_sum[XLEN];
            o_v      = (i_a[XLEN-1] == w_b_eff[XLEN-1]) && (o_result[XLEN-1] != i_a[XLEN-1]);
         end
         ALU_AND:   o_result = i_a & i_b;
         ALU_OR:    o_result = i_a | i_b;
         ALU_XOR:   o_result = i_a ^ i_b;
         ALU_SHIFT: o_result = i_shift_left ? (i_a << i_shamt) : (i_a >> i_shamt);
         default:   o_result = '0;
      endcase
      o_n = o_result[XLEN-1];
      o_z = (o_result == '0);
   end
endmodule

// File: rtl/arm_cpu_core.sv
// Single-cycle LEGv8-subset core: PC, 31 GPRs + XZR, NZVC flags, inline decode.
// Define ARM_SHIFT_EN to decode LSL/LSR; otherwise those opcodes execute as NOPs.
module arm_cpu_core
   import arm_cpu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic           clk,
   input  logic           rst,
   arm_cpu_core_if.master bus
);
   logic [XLEN-1:0] r_pc;
   logic [3:0]      r_flags;
   logic [XLEN-1:0] r_regs [0:30];

   logic [31:0]     w_instr;
   ctrl_t           w_ctrl;
   logic [4:0]      w_rd;
   logic [4:0]      w_rn;
   logic [4:0]      w_ra2;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_alu_b;
   logic [XLEN-1:0] w_alu_res;
   logic            w_n, w_z, w_v, w_c;
   logic [XLEN-1:0] w_wb;
   logic [XLEN-1:0] w_br_off;
   logic            w_taken;
   logic [XLEN-1:0] w_next_pc;

   assign w_instr = bus.imem_data;

   always_comb begin
      w_ctrl = '0;
      if (w_instr[31:22] == OP_ADDI) begin
         w_ctrl.regwrite = 1'b1;
         w_ctrl.alusrc   = 1'b1;
         w_ctrl.toadd    = 1'b1;
         w_ctrl.aluop    = ALU_ADD;
      end else if (w_instr[31:21] == OP_ADDS || w_instr[31:21] == OP_SUBS) begin
         w_ctrl.regwrite   = 1'b1;
         w_ctrl.flagenable = 1'b1;
         w_ctrl.aluop      = (w_instr[31:21] == OP_SUBS) ? ALU_SUB : ALU_ADD;
      end else if (w_instr[31:21] == OP_LDUR) begin
         w_ctrl.alusrc   = 1'b1;
         w_ctrl.memtoreg = 1'b1;
         w_ctrl.regwrite = 1'b1;
         w_ctrl.memread  = 1'b1;
         w_ctrl.aluop    = ALU_ADD;
      end else if (w_instr[31:21] == OP_STUR) begin
         w_ctrl.reg2loc  = 1'b1;
         w_ctrl.alusrc   = 1'b1;
         w_ctrl.memwrite = 1'b1;
         w_ctrl.aluop    = ALU_ADD;
      end
`ifdef ARM_SHIFT_EN
      else if (w_instr[31:21] == OP_LSL || w_instr[31:21] == OP_LSR) begin
         w_ctrl.regwrite = 1'b1;
         w_ctrl.aluop    = ALU_SHIFT;
      end
`endif
      else if (w_instr[31:26] == OP_B) begin
         w_ctrl.uncondbr = 1'b1;
      end else if (w_instr[31:24] == OP_BCOND && w_instr[4:0] == COND_LT) begin
         w_ctrl.branch = BR_LT;
      end else if (w_instr[31:24] == OP_CBZ) begin
         w_ctrl.reg2loc = 1'b1;
         w_ctrl.branch  = BR_CBZ;
         w_ctrl.aluop   = ALU_PASSB;
      end
   end

   assign w_rd  = w_instr[4:0];
   assign w_rn  = w_instr[9:5];
   assign w_ra2 = w_ctrl.reg2loc ? w_instr[4:0] : w_instr[20:16];
   assign w_rd1 = (w_rn  == 5'd31) ? '0 : r_regs[w_rn];
   assign w_rd2 = (w_ra2 == 5'd31) ? '0 : r_regs[w_ra2];

   assign w_imm   = w_ctrl.toadd ? {{(XLEN-12){1'b0}}, w_instr[21:10]}
                                 : {{(XLEN-9){w_instr[20]}}, w_instr[20:12]};
   assign w_alu_b = w_ctrl.alusrc ? w_imm : w_rd2;

   arm_alu u_alu (
      .i_a          (w_rd1),
      .i_b          (w_alu_b),
      .i_op         (w_ctrl.aluop),
      .i_shamt      (w_instr[15:10]),
      .i_shift_left (w_instr[21]),
      .o_result     (w_alu_res),
      .o_n          (w_n),
      .o_z          (w_z),
      .o_v          (w_v),
      .o_c          (w_c)
   );

   assign w_wb = w_ctrl.memtoreg ? bus.dmem_rdata : w_alu_res;

   // B.LT uses the flags stored before this instruction: N is bit 3, V is bit 1
   assign w_taken   = w_ctrl.uncondbr
                    | ((w_ctrl.branch == BR_LT)  & (r_flags[3] ^ r_flags[1]))
                    | ((w_ctrl.branch == BR_CBZ) & w_z);
   assign w_br_off  = w_ctrl.uncondbr ? {{(XLEN-28){w_instr[25]}}, w_instr[25:0], 2'b00}
                                      : {{(XLEN-21){w_instr[23]}}, w_instr[23:5], 2'b00};
   assign w_next_pc = w_taken ? (r_pc + w_br_off) : (r_pc + 64'd4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= RESET_PC;
         r_flags <= 4'b0;
      end else begin
         r_pc <= w_next_pc;
         if (w_ctrl.flagenable) r_flags <= {w_n, w_z, w_v, w_c};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 31; i++) r_regs[i] <= '0;
      end else if (w_ctrl.regwrite && w_rd != 5'd31) begin
         r_regs[w_rd] <= w_wb;
      end
   end

   assign bus.imem_addr  = r_pc;
   assign bus.dmem_addr  = w_alu_res;
   assign bus.dmem_wdata = w_rd2;
   assign bus.dmem_we    = w_ctrl.memwrite & rst;
   assign bus.dmem_re    = w_ctrl.memread;
   assign bus.flags      = r_flags;
endmodule

// File: tb/tb_arm_cpu_core.sv
// Self-checking bench for arm_cpu_core: directed vector table, reset sequences, random vs. reference model.
module tb_arm_cpu_core;
   localparam logic [10:0] T_ADDS = 11'b10101011000;
   localparam logic [10:0] T_SUBS = 11'b11101011000;
   localparam logic [10:0] T_LDUR = 11'b11111000010;
   localparam logic [10:0] T_STUR = 11'b11111000000;
   localparam logic [10:0] T_LSL  = 11'b11010011011;
   localparam logic [10:0] T_LSR  = 11'b11010011010;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   arm_cpu_core_if bus ();
   arm_cpu_core #(.RESET_PC(64'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [63:0] rdata;
      logic        we;
      logic        re;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] pc;
      logic [3:0]  flags;
   } vec_t;
   vec_t vecs[$];

   logic [63:0] m_x [32];
   logic [63:0] m_pc;
   logic [3:0]  m_flags;

   function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
      return {10'b1001000100, imm, rn, rd};
   endfunction
   function automatic logic [31:0] e_r(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                       input logic [4:0] rm, input logic [5:0] sh);
      return {op, rm, sh, rn, rd};
   endfunction
   function automatic logic [31:0] e_d(input logic [10:0] op, input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] imm);
      return {op, imm, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] e_b(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction
   function automatic logic [31:0] e_bc(input logic [18:0] imm, input logic [4:0] cond);
      return {8'b01010100, imm, cond};
   endfunction
   function automatic logic [31:0] e_cbz(input logic [4:0] rt, input logic [18:0] imm);
      return {8'b10110100, imm, rt};
   endfunction

   function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic [63:0] rd, input logic we,
                               input logic re, input logic [63:0] a, input logic [63:0] wd,
                               input logic [63:0] pc, input logic [3:0] fl);
      vec_t v;
      v.name = nm; v.instr = ins; v.rdata = rd; v.we = we; v.re = re;
      v.addr = a; v.wdata = wd; v.pc = pc; v.flags = fl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_x[i] = '0;
      m_pc    = 64'h0;
      m_flags = 4'b0;
   endtask

   task automatic m_wr(input logic [4:0] r, input logic [63:0] val);
      if (r != 5'd31) m_x[r] = val;
   endtask

   // Reference model: one architectural instruction per call
   task automatic model_step(input logic [31:0] ins, input logic [63:0] rdata, output logic we,
                             output logic re, output logic [63:0] addr, output logic [63:0] wdata);
      logic [63:0] xa, xb, xt, res, se9, npc;
      logic [64:0] u;
      logic signed [64:0] s;
      logic sub, n, z, v, c;
      xa  = m_x[ins[9:5]];
      xb  = m_x[ins[20:16]];
      xt  = m_x[ins[4:0]];
      se9 = {{55{ins[20]}}, ins[20:12]};
      npc = m_pc + 64'd4;
      we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
      if (ins[31:22] == 10'b1001000100) begin
         m_wr(ins[4:0], xa + {52'b0, ins[21:10]});
      end else if (ins[31:21] == T_ADDS || ins[31:21] == T_SUBS) begin
         sub = (ins[31:21] == T_SUBS);
         if (sub) begin
            u = {1'b0, xa} - {1'b0, xb};
            s = $signed({xa[63], xa}) - $signed({xb[63], xb});
            c = (xa >= xb);
         end else begin
            u = {1'b0, xa} + {1'b0, xb};
            s = $signed({xa[63], xa}) + $signed({xb[63], xb});
            c = u[64];
         end
         res = u[63:0];
         n = res[63];
         z = (res == 64'h0);
         v = (s != $signed({res[63], res}));
         m_flags = {n, z, v, c};
         m_wr(ins[4:0], res);
      end else if (ins[31:21] == T_LDUR) begin
         re = 1'b1; addr = xa + se9;
         m_wr(ins[4:0], rdata);
      end else if (ins[31:21] == T_STUR) begin
         we = 1'b1; addr = xa + se9; wdata = xt;
      end
`ifdef ARM_SHIFT_EN
      else if (ins[31:21] == T_LSL) begin
         m_wr(ins[4:0], xa << ins[15:10]);
      end else if (ins[31:21] == T_LSR) begin
         m_wr(ins[4:0], xa >> ins[15:10]);
      end
`endif
      else if (ins[31:26] == 6'b000101) begin
         npc = m_pc + ({{38{ins[25]}}, ins[25:0]} << 2);
      end else if (ins[31:24] == 8'b01010100 && ins[4:0] == 5'b01011) begin
         if (m_flags[3] != m_flags[1]) npc = m_pc + ({{45{ins[23]}}, ins[23:5]} << 2);
      end else if (ins[31:24] == 8'b10110100) begin
         if (xt == 64'h0) npc = m_pc + ({{45{ins[23]}}, ins[23:5]} << 2);
      end
      m_pc = npc;
   endtask

   task automatic run_model(input logic [31:0] ins, input logic [63:0] rd);
      logic we, re;
      logic [63:0] a, wd;
      bus.imem_data  = ins;
      bus.dmem_rdata = rd;
      #2;
      chk("rnd_pc", bus.imem_addr, m_pc);
      model_step(ins, rd, we, re, a, wd);
      chk("rnd_we", 64'(bus.dmem_we), 64'(we));
      chk("rnd_re", 64'(bus.dmem_re), 64'(re));
      if (we || re) chk("rnd_addr", bus.dmem_addr, a);
      if (we) chk("rnd_wdata", bus.dmem_wdata, wd);
      @(posedge clk); #1;
      chk("rnd_flags", 64'(bus.flags), 64'(m_flags));
   endtask

   function automatic logic [4:0] rnd_reg();
      int k;
      k = $urandom_range(0, 6);
      return (k == 6) ? 5'd31 : 5'(k);
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [18:0] o19;
      logic [25:0] o26;
      o19 = 19'($signed($urandom_range(0, 8)) - 4);
      o26 = 26'($signed($urandom_range(0, 8)) - 4);
      case ($urandom_range(0, 11))
         0:  return e_addi(rnd_reg(), rnd_reg(), 12'($urandom));
         1:  return e_r(T_ADDS, rnd_reg(), rnd_reg(), rnd_reg(), 6'd0);
         2:  return e_r(T_SUBS, rnd_reg(), rnd_reg(), rnd_reg(), 6'd0);
         3:  return e_d(T_LDUR, rnd_reg(), rnd_reg(), 9'($urandom));
         4:  return e_d(T_STUR, rnd_reg(), rnd_reg(), 9'($urandom));
         5:  return e_b(o26);
         6:  return e_bc(o19, 5'b01011);
         7:  return e_bc(o19, 5'($urandom));
         8:  return e_cbz(rnd_reg(), o19);
         9:  return e_r(T_LSL, rnd_reg(), rnd_reg(), 5'd0, 6'($urandom));
         10: return e_r(T_LSR, rnd_reg(), rnd_reg(), 5'd0, 6'($urandom));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [63:0] sh_lsl, sh_lsr;
`ifdef ARM_SHIFT_EN
      sh_lsl = 64'd16; sh_lsr = 64'd7;
`else
      sh_lsl = 64'd0;  sh_lsr = 64'd0;
`endif
      vecs.push_back(mk("addi_x1",     e_addi(1, 31, 12'd5),         0, 0, 0, 0, 0, 64'h04, 4'b0000));
      vecs.push_back(mk("addi_x2",     e_addi(2, 31, 12'd3),         0, 0, 0, 0, 0, 64'h08, 4'b0000));
      vecs.push_back(mk("subs_pos",    e_r(T_SUBS, 3, 1, 2, 0),      0, 0, 0, 0, 0, 64'h0C, 4'b0001));
      vecs.push_back(mk("stur_x3",     e_d(T_STUR, 3, 31, 9'd0),     0, 1, 0, 64'h0, 64'd2, 64'h10, 4'b0001));
      vecs.push_back(mk("subs_neg",    e_r(T_SUBS, 4, 2, 1, 0),      0, 0, 0, 0, 0, 64'h14, 4'b1000));
      vecs.push_back(mk("blt_taken",   e_bc(19'd3, 5'b01011),        0, 0, 0, 0, 0, 64'h20, 4'b1000));
      vecs.push_back(mk("subs_swap",   e_r(T_SUBS, 4, 1, 2, 0),      0, 0, 0, 0, 0, 64'h24, 4'b0001));
      vecs.push_back(mk("blt_not",     e_bc(19'd3, 5'b01011),        0, 0, 0, 0, 0, 64'h28, 4'b0001));
      vecs.push_back(mk("stur_x1_8",   e_d(T_STUR, 1, 31, 9'd8),     0, 1, 0, 64'h8, 64'd5, 64'h2C, 4'b0001));
      vecs.push_back(mk("ldur_x5",     e_d(T_LDUR, 5, 31, 9'd8),     64'd5, 0, 1, 64'h8, 0, 64'h30, 4'b0001));
      vecs.push_back(mk("addi_x6",     e_addi(6, 31, 12'd16),        0, 0, 0, 0, 0, 64'h34, 4'b0001));
      vecs.push_back(mk("ldur_negoff", e_d(T_LDUR, 7, 6, 9'h1F8),    64'h1234, 0, 1, 64'h8, 0, 64'h38, 4'b0001));
      vecs.push_back(mk("stur_x5",     e_d(T_STUR, 5, 31, 9'd0),     0, 1, 0, 64'h0, 64'd5, 64'h3C, 4'b0001));
      vecs.push_back(mk("stur_x7",     e_d(T_STUR, 7, 31, 9'd0),     0, 1, 0, 64'h0, 64'h1234, 64'h40, 4'b0001));
      vecs.push_back(mk("cbz_xzr",     e_cbz(31, 19'h7FFFE),         0, 0, 0, 0, 0, 64'h38, 4'b0001));
      vecs.push_back(mk("cbz_nz",      e_cbz(1, 19'd3),              0, 0, 0, 0, 0, 64'h3C, 4'b0001));
      vecs.push_back(mk("b_minus1",    e_b(26'h3FFFFFF),             0, 0, 0, 0, 0, 64'h38, 4'b0001));
      vecs.push_back(mk("ldur_max",    e_d(T_LDUR, 1, 31, 9'd0),     64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 64'h0, 0, 64'h3C, 4'b0001));
      vecs.push_back(mk("addi_x2_1",   e_addi(2, 31, 12'd1),         0, 0, 0, 0, 0, 64'h40, 4'b0001));
      vecs.push_back(mk("adds_ovf",    e_r(T_ADDS, 10, 1, 2, 0),     0, 0, 0, 0, 0, 64'h44, 4'b1010));
      vecs.push_back(mk("stur_x10",    e_d(T_STUR, 10, 31, 9'd0),    0, 1, 0, 64'h0, 64'h8000_0000_0000_0000, 64'h48, 4'b1010));
      vecs.push_back(mk("blt_nv_eq",   e_bc(19'd3, 5'b01011),        0, 0, 0, 0, 0, 64'h4C, 4'b1010));
      vecs.push_back(mk("addi_xzr",    e_addi(31, 1, 12'd5),         0, 0, 0, 0, 0, 64'h50, 4'b1010));
      vecs.push_back(mk("stur_xzr",    e_d(T_STUR, 31, 31, 9'd0),    0, 1, 0, 64'h0, 64'h0, 64'h54, 4'b1010));
      vecs.push_back(mk("undef_nop",   32'h0,                        0, 0, 0, 0, 0, 64'h58, 4'b1010));
      vecs.push_back(mk("lsl",         e_r(T_LSL, 11, 2, 0, 6'd4),   0, 0, 0, 0, 0, 64'h5C, 4'b1010));
      vecs.push_back(mk("stur_lsl",    e_d(T_STUR, 11, 31, 9'd0),    0, 1, 0, 64'h0, sh_lsl, 64'h60, 4'b1010));
      vecs.push_back(mk("subs_zero",   e_r(T_SUBS, 12, 2, 2, 0),     0, 0, 0, 0, 0, 64'h64, 4'b0101));
      vecs.push_back(mk("blt_zero",    e_bc(19'd3, 5'b01011),        0, 0, 0, 0, 0, 64'h68, 4'b0101));
      vecs.push_back(mk("cbz_taken",   e_cbz(12, 19'd2),             0, 0, 0, 0, 0, 64'h70, 4'b0101));
      vecs.push_back(mk("lsr",         e_r(T_LSR, 13, 1, 0, 6'd60),  0, 0, 0, 0, 0, 64'h74, 4'b0101));
      vecs.push_back(mk("stur_lsr",    e_d(T_STUR, 13, 31, 9'd0),    0, 1, 0, 64'h0, sh_lsr, 64'h78, 4'b0101));

      // Held in reset with a store on the fetch port: no write strobe may escape
      bus.imem_data  = e_d(T_STUR, 1, 31, 9'd0);
      bus.dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 64'(bus.dmem_we), 64'd0);
      chk("rst_pc", bus.imem_addr, 64'h0);
      chk("rst_flags", 64'(bus.flags), 64'd0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         bus.imem_data  = vecs[i].instr;
         bus.dmem_rdata = vecs[i].rdata;
         #2;
         chk({vecs[i].name, "_we"}, 64'(bus.dmem_we), 64'(vecs[i].we));
         chk({vecs[i].name, "_re"}, 64'(bus.dmem_re), 64'(vecs[i].re));
         if (vecs[i].we || vecs[i].re) chk({vecs[i].name, "_addr"}, bus.dmem_addr, vecs[i].addr);
         if (vecs[i].we) chk({vecs[i].name, "_wdata"}, bus.dmem_wdata, vecs[i].wdata);
         @(posedge clk); #1;
         chk({vecs[i].name, "_pc"}, bus.imem_addr, vecs[i].pc);
         chk({vecs[i].name, "_flags"}, 64'(bus.flags), 64'(vecs[i].flags));
      end

      // Asynchronous reset mid-cycle clears PC and flags without waiting for a clock
      bus.imem_data = e_d(T_STUR, 1, 31, 9'd0);
      rst = 1'b0;
      #1;
      chk("async_rst_pc", bus.imem_addr, 64'h0);
      chk("async_rst_flags", 64'(bus.flags), 64'd0);
      chk("async_rst_we", 64'(bus.dmem_we), 64'd0);
      #1;
      rst = 1'b1;
      m_reset();

      // Register dump after reset confirms every GPR was cleared
      for (int r = 0; r < 32; r++) run_model(e_d(T_STUR, 5'(r), 31, 9'd0), 64'h0);

      for (int i = 0; i < 2000; i++) begin
         run_model(rnd_instr(), {$urandom, $urandom});
         if (i % 100 == 99)
            for (int r = 0; r < 6; r++) run_model(e_d(T_STUR, 5'(r), 31, 9'd0), 64'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
